ins_fetch: RTL and testbench
============================

# ins_fetch

Instruction fetch stage directly upstream of the control unit. It holds the program counter, runs a request/acknowledge handshake with instruction memory, and latches each returned word into an instruction register. It presents the decoded fields (4-bit opcode plus register/immediate fields) to the control unit and register file with a valid/ready handshake. It also accepts a PC redirect for jumps and branches.

## Interface
- IW, 16: instruction width; fields op[15:12], rd[11:8], rs[7:4], rt/imm[3:0]; IW fixed at 16 in this revision
- AW, 8: PC/address width
- RESET_PC, 0: PC value after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; when low, no new fetch is started
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
- imem_rdata  in  IW  returned instruction word
- redirect_valid  in  1  one-cycle pulse: load PC from redirect_pc
- redirect_pc  in  AW  jump/branch target
- ins_valid  out  1  ins_* fields hold a valid instruction
- ins_ready  in  1  downstream accepts the instruction
- ins_op  out  4  opcode to the control unit
- ins_rd, ins_rs, ins_rt  out  4 each  register/immediate fields
- ins_pc  out  AW  address the current instruction was fetched from

## Operation
- FSM states: IDLE, REQ, HOLD. Reset state is IDLE.
- IDLE: imem_req=0. If en=1, go to REQ.
- REQ: imem_req=1 and imem_addr=pc.
  - On imem_ack: IR<=imem_rdata, ins_pc<=pc, pc<=pc+1 (modulo 2^AW, so 2^AW-1 wraps to 0), go to HOLD.
- HOLD: ins_valid=1 and the ins_* fields are stable.
  - On ins_ready: go to REQ if en=1, else IDLE.
- A low en never aborts an outstanding request. REQ runs to ack, and the stage then parks in IDLE after the handoff.
- Redirect, in any state:
  - pc<=redirect_pc.
  - The IR is squashed: ins_valid=0 from the next cycle.
  - If REQ is outstanding with no ack in the same cycle, set the drop flag. The request completes at the old address, the returned data is discarded, and REQ is reissued at redirect_pc.
  - Redirect in the same cycle as imem_ack: the data is discarded and no drop flag is set.
  - Redirect in the same cycle as an ins_ready handshake: that instruction counts as consumed, and the redirect still applies.
- imem_req never drops before imem_ack.
- The ins_* fields must not change while ins_valid=1 and ins_ready=0.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ins_valid=0, IR=0 (ins_op, rd, rs, rt all 0), ins_pc=0, drop flag=0.
- Assertion of rst_n mid-request abandons the request immediately. Memory must tolerate imem_req dropping on reset.

## Timing
- All outputs are registered. imem_addr is driven from pc.
- Latency from imem_ack to ins_valid is one cycle.
- Without the prefetch feature: at most 1 instruction per 2 cycles, with zero-wait memory and ins_ready held high.
- Redirect to first imem_req at redirect_pc:
  - next cycle if no request is outstanding;
  - otherwise the cycle after the dropped ack.

## Configuration
- INS_FETCH_PREFETCH_EN defined:
  - Adds a one-entry prefetch buffer. While in HOLD, the next fetch is issued.
  - The returned word lands in the buffer and moves into the IR on the ins_ready cycle.
  - Sustains 1 instruction per cycle with zero-wait memory.
  - A redirect squashes both the buffer and the IR.
  - The buffer full condition stalls new requests.
- Undefined: plain 3-state FSM only, with no buffer logic synthesized.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD=4'd0, OP_IADD=4'd1, OP_ST=4'd2, OP_LD=4'd3, shared with the control unit;
  - field bit positions;
  - the fetch state encoding.
- Sub-module ins_fetch_buf: a one-entry {word, pc} register with valid and squash.
  - Instantiated once for the IR, and once more for the prefetch buffer when INS_FETCH_PREFETCH_EN is defined.

## Test plan
- Reset, en=1, zero-wait memory returning 16'h1123 at address 0 -> imem_addr=0; next cycle ins_valid=1, ins_op=1, ins_rd=1, ins_rs=2, ins_rt=3, ins_pc=0; pc=1.
- ins_ready held low for 5 cycles -> fields stable and no new imem_req (without prefetch).
- ack delayed 3 cycles -> imem_req and imem_addr stable throughout; exactly one IR load.
- RESET_PC=8'hFF -> second fetch at address 8'h00.
- redirect_valid with redirect_pc=8'h40 while a request to 8'h05 is pending -> the 8'h05 data is dropped and never reaches ins_valid; next imem_addr=8'h40.
- With INS_FETCH_PREFETCH_EN, zero-wait memory, ins_ready=1 -> ins_pc increments by 1 every cycle after the first.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch FSM encoding.
// Used by the fetch stage and the control unit.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_IADD = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_st_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_LD);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_IADD);
  endfunction

endpackage

// File: rtl/ins_fetch_buf.sv
// One-entry {word, pc} holding register with valid, load, consume and squash.
// Load wins over consume, so a simultaneous drain-and-refill keeps the entry valid.
module ins_fetch_buf
  import cpu_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic          squash,
  input  logic [IW-1:0] load_word,
  input  logic [AW-1:0] load_pc,
  output logic          vld,
  output logic [IW-1:0] word,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      word <= '0;
      pc   <= '0;
    end else begin
      if (squash)
        vld <= 1'b0;
      else if (load)
        vld <= 1'b1;
      else if (clear)
        vld <= 1'b0;
      if (load && !squash) begin
        word <= load_word;
        pc   <= load_pc;
      end
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: PC, imem req/ack handshake, IR with valid/ready to decode; ack-to-valid one cycle.
// INS_FETCH_PREFETCH_EN adds a one-entry prefetch buffer for 1 instr/cycle; a full buffer stalls requests.
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int            IW       = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [3:0]    ins_op,
  output logic [3:0]    ins_rd,
  output logic [3:0]    ins_rs,
  output logic [3:0]    ins_rt,
  output logic [AW-1:0] ins_pc
);

  fetch_st_t     st;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_n;
  logic          drop;
  logic          ack_keep;
  logic          ir_take;
  logic          start_ok;
  logic          ir_vld;
  logic [IW-1:0] ir_word;
  logic          ir_load;
  logic [IW-1:0] ir_load_word;
  logic [AW-1:0] ir_load_pc;

  // Returned data is kept only if it was not fetched before a redirect.
  assign ack_keep = imem_req && imem_ack && !drop && !redirect_valid;
  assign ir_take  = ir_vld && ins_ready;

  always_comb begin
    pc_n = pc;
    if (redirect_valid)
      pc_n = redirect_pc;
    else if (ack_keep)
      pc_n = pc + AW'(1);
  end

`ifdef INS_FETCH_PREFETCH_EN
  logic          pb_vld;
  logic [IW-1:0] pb_word;
  logic [AW-1:0] pb_pc;
  logic          ir_free;
  logic          pb_load;
  logic          pb_clear;
  logic          pb_vld_n;

  assign ir_free      = !ir_vld || ins_ready;
  assign ir_load      = ir_free && (pb_vld || ack_keep);
  assign ir_load_word = pb_vld ? pb_word : imem_rdata;
  assign ir_load_pc   = pb_vld ? pb_pc : pc;
  assign pb_load      = ack_keep && (pb_vld || !ir_free);
  assign pb_clear     = pb_vld && ir_free;
  assign pb_vld_n     = !redirect_valid && (pb_load || (pb_vld && !ir_free));
  // A new request may only start if its data is guaranteed a landing slot.
  assign start_ok     = en && !pb_vld_n;

  ins_fetch_buf #(.IW(IW), .AW(AW)) u_pbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pb_load),
    .clear     (pb_clear),
    .squash    (redirect_valid),
    .load_word (imem_rdata),
    .load_pc   (pc),
    .vld       (pb_vld),
    .word      (pb_word),
    .pc        (pb_pc)
  );
`else
  assign ir_load      = ack_keep;
  assign ir_load_word = imem_rdata;
  assign ir_load_pc   = pc;
  assign start_ok     = en;
`endif

  ins_fetch_buf #(.IW(IW), .AW(AW)) u_ir (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ir_load),
    .clear     (ir_take),
    .squash    (redirect_valid),
    .load_word (ir_load_word),
    .load_pc   (ir_load_pc),
    .vld       (ir_vld),
    .word      (ir_word),
    .pc        (ins_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FETCH_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      pc        <= RESET_PC;
      drop      <= 1'b0;
    end else begin
      pc <= pc_n;
      // Address is frozen only while a request is waiting for its ack.
      if (!(imem_req && !imem_ack))
        imem_addr <= pc_n;
      case (st)
        FETCH_IDLE: begin
          if (start_ok) begin
            st       <= FETCH_REQ;
            imem_req <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (imem_ack) begin
            drop <= 1'b0;
`ifdef INS_FETCH_PREFETCH_EN
            if (start_ok) begin
              st       <= FETCH_REQ;
              imem_req <= 1'b1;
            end else begin
              st       <= FETCH_IDLE;
              imem_req <= 1'b0;
            end
`else
            if (ack_keep) begin
              st       <= FETCH_HOLD;
              imem_req <= 1'b0;
            end else if (start_ok) begin
              st       <= FETCH_REQ;
              imem_req <= 1'b1;
            end else begin
              st       <= FETCH_IDLE;
              imem_req <= 1'b0;
            end
`endif
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (redirect_valid || ir_take) begin
            st       <= en ? FETCH_REQ : FETCH_IDLE;
            imem_req <= en;
          end
        end
        default: begin
          st       <= FETCH_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign ins_valid = ir_vld;
  assign ins_op    = ir_word[OP_MSB:OP_LSB];
  assign ins_rd    = ir_word[RD_MSB:RD_LSB];
  assign ins_rs    = ir_word[RS_MSB:RS_LSB];
  assign ins_rt    = ir_word[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed timing cases plus random traffic against an in-order fetch model.
// Expected stream: consecutive addresses from the reset PC, restarting at each redirect target.
module tb_ins_fetch;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ins_valid;
  logic          ins_ready;
  logic [3:0]    ins_op, ins_rd, ins_rs, ins_rt;
  logic [AW-1:0] ins_pc;

  always #5 clk = ~clk;

  ins_fetch #(.IW(IW), .AW(AW), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_op         (ins_op),
    .ins_rd         (ins_rd),
    .ins_rs         (ins_rs),
    .ins_rt         (ins_rt),
    .ins_pc         (ins_pc)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [IW-1:0] mem [256];
  int            lat = 0;
  int            wait_cnt = 0;
  logic [AW-1:0] exp_pc;
  int            n_deliv = 0;
  logic          last_ack = 1'b0;

  logic          have_prev = 1'b0;
  logic          p_vld, p_rdy, p_redir, p_req, p_ack;
  logic [AW-1:0] p_addr, p_pc;
  logic [IW-1:0] p_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: called at a falling edge, drives inputs, models memory and the
  // expected stream, then advances to the next falling edge.
  task automatic cycle(input logic e, input logic r, input logic rv, input logic [AW-1:0] rpc);
    logic [IW-1:0] cur_word;
    cur_word = {ins_op, ins_rd, ins_rs, ins_rt};
    en             = e;
    ins_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (have_prev) begin
      if (p_req && !p_ack) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", 32'(imem_addr), 32'(p_addr));
      end
      if (p_vld && !p_rdy && !p_redir)
        check("ins_held", {7'd0, ins_valid, ins_pc, cur_word}, {7'd0, 1'b1, p_pc, p_word});
    end
    if (imem_req && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr];
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
    if (ins_valid && r) begin
      check("deliv_pc", 32'(ins_pc), 32'(exp_pc));
      check("deliv_word", 32'(cur_word), 32'(mem[exp_pc]));
      exp_pc++;
      n_deliv++;
    end
    if (rv) exp_pc = rpc;
    p_vld     = ins_valid;
    p_rdy     = r;
    p_redir   = rv;
    p_req     = imem_req;
    p_ack     = imem_ack;
    p_addr    = imem_addr;
    p_pc      = ins_pc;
    p_word    = cur_word;
    have_prev = 1'b1;
    last_ack  = imem_ack;
    wait_cnt  = imem_ack ? 0 : (imem_req ? wait_cnt + 1 : 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    int d0;
    rst_n          = 1'b0;
    en             = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123;
    exp_pc = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_vld", 32'(ins_valid), 32'd0);
    check("rst_fields", {16'd0, ins_op, ins_rd, ins_rs, ins_rt}, 32'd0);
    check("rst_pc", 32'(ins_pc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(imem_req), 32'd0);

`ifndef INS_FETCH_PREFETCH_EN
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("first_vld", 32'(ins_valid), 32'd1);
    check("first_fields", {16'd0, ins_op, ins_rd, ins_rs, ins_rt}, 32'h1123);
    check("first_pc", 32'(ins_pc), 32'h00);
    check("first_req_off", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      check("stall_vld", 32'(ins_valid), 32'd1);
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("second_req", 32'(imem_req), 32'd1);
    check("second_addr", 32'(imem_addr), 32'h01);

    lat = 3;
    waited = 0;
    while (!ins_valid && waited < 10) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      waited++;
    end
    check("slow_ack_cycles", 32'(waited), 32'd4);
    check("slow_pc", 32'(ins_pc), 32'h01);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("single_load", 32'(ins_valid), 32'd0);

    lat = 0;
    waited = 0;
    while (!(imem_req && imem_addr == 8'h05) && waited < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      waited++;
    end
    check("reach_5", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h05});
    lat = 3;
    cycle(1'b1, 1'b1, 1'b1, 8'h40);
    waited = 0;
    last_ack = 1'b0;
    while (!last_ack && waited < 10) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      waited++;
    end
    check("drop_ack_seen", 32'(last_ack), 32'd1);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h40);
    check("redir_no_vld", 32'(ins_valid), 32'd0);

    lat = 0;
    d0 = n_deliv;
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("rate_half", 32'(n_deliv - d0), 32'd10);

    cycle(1'b1, 1'b1, 1'b1, 8'hFF);
    check("redir_ack_req", 32'(imem_req), 32'd1);
    check("redir_ack_addr", 32'(imem_addr), 32'hFF);
    check("redir_ack_vld", 32'(ins_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("wrap_pc", 32'(ins_pc), 32'hFF);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("wrap_addr", 32'(imem_addr), 32'h00);

    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("en_low_completes", 32'(ins_valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("en_low_parks", 32'(imem_req), 32'd0);
`else
    lat = 0;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    d0 = n_deliv;
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("rate_full", 32'(n_deliv - d0), 32'd20);
`endif

    d0 = n_deliv;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, 8'($urandom));
    end
    check("rand_progress", 32'(n_deliv - d0 > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
